uart_rx_unit: RTL and testbench
===============================

# uart_rx_unit

UART receiver that deserialises the board RX pin into bytes for the debug unit. It delivers each byte as a held `o_rx_flag_ready` / `o_rx_data` pair. The flag stays up until the debug unit clears it through its `uart_rx_reset` output. The block sits between the FPGA RX pad and the debug state machine, which reads command characters (`c`, `s`, `d`, `n`) and instruction bytes from it.

## Interface
- `CLK_FREQ`, 50_000_000: system clock frequency in Hz.
- `BAUD_RATE`, 9600: line rate in bit/s.
- `OVERSAMPLE`, 16: ticks per bit. Must be even and ≥ 4.
- `SIZE_TRAMA`, 8: data bits per frame.
- `i_clk`, input, 1: system clock. All logic is on its rising edge.
- `i_reset`, input, 1: one clock; reset is asynchronous and active-low (`i_reset`=0 resets).
- `i_rx`, input, 1: asynchronous serial line. Idle level is 1.
- `i_rx_clear`, input, 1: level clear from the debug unit (its `o_uart_rx_reset`).
- `o_rx_flag_ready`, output, 1: a byte is available. Held until cleared.
- `o_rx_data`, output, `SIZE_TRAMA`: last good byte, LSB received first.
- `o_rx_overrun`, output, 1: sticky. A byte completed while the flag was already set.
- `o_frame_error`, output, 1: sticky. The stop bit was sampled as 0.
- `o_rx_busy`, output, 1: the FSM is not in IDLE.

## Operation
- **Synchroniser.** `i_rx` passes through 2 flops, both resetting to 1. All logic uses the synchronised value `rx_s`.
- **Tick generator.**
  - `DIVISOR = CLK_FREQ / (BAUD_RATE*OVERSAMPLE)`, integer division, minimum 1.
  - Counter width is `$clog2(DIVISOR)`, minimum 1 bit.
  - The tick is a 1-cycle pulse when the counter reaches `DIVISOR-1`. The counter then wraps to 0.
  - The counter is free-running except that it is forced to 0 on the IDLE→START transition.
- **FSM states:** IDLE, START, DATA, STOP.
  - **IDLE:** when `rx_s`=0, go to START. Reset the tick counter and the oversample counter.
  - **START:** count ticks. At tick `OVERSAMPLE/2-1` (mid start bit), sample `rx_s`.
    - If 1: false start, return to IDLE.
    - If 0: clear the oversample counter and go to DATA with bit index 0.
  - **DATA:** every `OVERSAMPLE` ticks, sample `rx_s` into the shift register (`{rx_s, shreg[SIZE_TRAMA-1:1]}`) and increment the bit index. After bit `SIZE_TRAMA-1`, go to STOP.
  - **STOP:** after `OVERSAMPLE` ticks, sample `rx_s`.
    - If 1: load `o_rx_data` from shreg and set `o_rx_flag_ready`.
    - If 0: set `o_frame_error`. Leave data and flag unchanged.
    - In both cases return to IDLE. A new start bit is accepted on the next cycle.
- **Flag / clear priority** (evaluated each cycle):
  - Good-byte completion sets the flag, even if `i_rx_clear`=1 in the same cycle. The new byte is never lost.
  - Otherwise `i_rx_clear`=1 clears the flag, `o_rx_overrun` and `o_frame_error`.
  - Completion while the flag is set and `i_rx_clear`=0 overwrites `o_rx_data` and sets `o_rx_overrun`.
- **Clear independence.** `i_rx_clear` never aborts a frame in progress. The debug unit holds clear high from reset until its IDLE state, and reception proceeds regardless.
- **Reset values:**
  - `o_rx_flag_ready`=0, `o_rx_data`=0, `o_rx_overrun`=0, `o_frame_error`=0, `o_rx_busy`=0.
  - FSM = IDLE; all counters = 0.
- **Reset mid-frame** aborts immediately. After release the block waits in IDLE for the next falling edge. A low level still present on the line is taken as a start bit and normally fails the mid-bit check only if the line has returned high.

## Timing
- Start-edge to first falling `rx_s`: 2 cycles of synchroniser latency.
- **Sampling points:** in START after `OVERSAMPLE/2` ticks; each DATA bit at 16-tick spacing after that (for `OVERSAMPLE`=16); the stop bit at (`SIZE_TRAMA`+1)·`OVERSAMPLE` + `OVERSAMPLE/2` ticks after the edge is detected.
- The flag rises on the clock after the stop-bit sample tick. `o_rx_data` is valid in the same cycle as the flag and stable while the flag is high.
- `o_rx_busy` is high from the cycle after detection until the cycle the FSM returns to IDLE.
- Clear takes effect on the next edge, so the flag is low one cycle after `i_rx_clear` is sampled high.

## Structure
- A shared package `uart_pkg` holds:
  - the FSM state encoding (2-bit: IDLE=0, START=1, DATA=2, STOP=3);
  - the command constants `CMD_CONT`=8'h63, `CMD_STEP`=8'h73, `CMD_LOAD`=8'h64, `CMD_NEXT`=8'h6E;
  - the divisor function.
- Sub-module `baud_tick_gen`: the divisor counter with a synchronous restart input. It is shared with the future transmitter.

## Test plan
Use sim parameters `CLK_FREQ`=1_600_000, `BAUD_RATE`=100_000, `OVERSAMPLE`=16. This gives a divisor of 1, so one bit lasts 16 clocks.

- **Single byte.** Send 0x63 with a good stop bit, then idle.
  - Flag rises exactly 2+8+16·9+… cycles per the sampling formula, with `o_rx_data`=0x63.
  - Flag stays high until `i_rx_clear`, then drops 1 cycle later.
- **False start.** Drive a 5-cycle low glitch. `o_rx_busy` pulses, then returns to IDLE. Flag stays 0 and data stays 0.
- **Framing error.** Send 0x55 with stop bit 0. `o_frame_error`=1, flag stays 0, `o_rx_data` keeps its previous value. Asserting `i_rx_clear` clears the error.
- **Overrun.** Send 0x73 then 0x6E without clearing. Data=0x6E, flag=1, `o_rx_overrun`=1.
- **Simultaneous clear and completion.** Hold `i_rx_clear`=1 across the completion of 0xFF. Flag=1 and data=0xFF after completion. The flag clears once clear is held one more cycle.
- **Async reset mid-frame.** Pull `i_reset` low during bit 3 of 0xA5. All outputs go to 0 without a clock. After release, a full 0x64 is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding, debug command characters
// and the baud divisor helpers used by the receiver and the future transmitter.
package uart_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } uart_state_e;

    localparam logic [7:0] CMD_CONT = 8'h63;
    localparam logic [7:0] CMD_STEP = 8'h73;
    localparam logic [7:0] CMD_LOAD = 8'h64;
    localparam logic [7:0] CMD_NEXT = 8'h6E;

    // Clocks per oversample tick, never below 1 so a tick always exists.
    function automatic int calc_divisor(input int clk_freq, input int baud_rate,
                                        input int oversample);
        int d;
        d = clk_freq / (baud_rate * oversample);
        return (d < 1) ? 1 : d;
    endfunction

    function automatic int width_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Free-running oversample tick divisor with a synchronous restart, so a
// receiver can phase-align its ticks to the detected start edge.
module baud_tick_gen
    import uart_pkg::*;
#(
    parameter int DIVISOR = 1
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_restart,
    output logic o_tick
);

    localparam int CW = width_min1(DIVISOR);
    localparam logic [CW-1:0] CNT_LAST = CW'(DIVISOR - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (i_restart || (cnt_q == CNT_LAST)) begin
            cnt_d = '0;
        end
    end

    assign o_tick = (cnt_q == CNT_LAST);

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_unit.sv
// UART receiver for the debug unit: synchronises RX, deserialises LSB-first
// frames and holds each good byte behind a flag until the debug unit clears it.
module uart_rx_unit
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int SIZE_TRAMA = 8
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_rx,
    input  logic                  i_rx_clear,
    output logic                  o_rx_flag_ready,
    output logic [SIZE_TRAMA-1:0] o_rx_data,
    output logic                  o_rx_overrun,
    output logic                  o_frame_error,
    output logic                  o_rx_busy
);

    localparam int DIVISOR = calc_divisor(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
    localparam int OW      = width_min1(OVERSAMPLE);
    localparam int BW      = width_min1(SIZE_TRAMA);

    localparam logic [OW-1:0] OS_MID   = OW'(OVERSAMPLE / 2 - 1);
    localparam logic [OW-1:0] OS_LAST  = OW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(SIZE_TRAMA - 1);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic rx_s;

    uart_state_e            state_q, state_d;
    logic [OW-1:0]          os_cnt_q, os_cnt_d;
    logic [BW-1:0]          bit_idx_q, bit_idx_d;
    logic [SIZE_TRAMA-1:0]  shreg_q, shreg_d;
    logic [SIZE_TRAMA-1:0]  data_q, data_d;
    logic                   flag_q, flag_d;
    logic                   overrun_q, overrun_d;
    logic                   frame_err_q, frame_err_d;

    logic tick;
    logic restart;
    logic done_good;
    logic done_bad;

    // Debug view of the receiver FSM for checkers and waveform reading.
    uart_state_e dbg_state;
    assign dbg_state = state_q;

    always_comb begin
        sync1_d = i_rx;
        sync2_d = sync1_q;
    end

    assign rx_s = sync2_q;

    // Holding the divisor in restart while idle aligns ticks to the start edge.
    assign restart = (state_q == S_IDLE);

    baud_tick_gen #(
        .DIVISOR (DIVISOR)
    ) u_tick (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_restart (restart),
        .o_tick    (tick)
    );

    always_comb begin
        state_d   = state_q;
        os_cnt_d  = os_cnt_q;
        bit_idx_d = bit_idx_q;
        shreg_d   = shreg_q;
        done_good = 1'b0;
        done_bad  = 1'b0;
        case (state_q)
            S_IDLE: begin
                os_cnt_d  = '0;
                bit_idx_d = '0;
                if (!rx_s) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (tick) begin
                    if (os_cnt_q == OS_MID) begin
                        os_cnt_d  = '0;
                        bit_idx_d = '0;
                        state_d   = rx_s ? S_IDLE : S_DATA;
                    end else begin
                        os_cnt_d = os_cnt_q + 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (tick) begin
                    if (os_cnt_q == OS_LAST) begin
                        os_cnt_d = '0;
                        shreg_d  = {rx_s, shreg_q[SIZE_TRAMA-1:1]};
                        if (bit_idx_q == BIT_LAST) begin
                            state_d = S_STOP;
                        end else begin
                            bit_idx_d = bit_idx_q + 1'b1;
                        end
                    end else begin
                        os_cnt_d = os_cnt_q + 1'b1;
                    end
                end
            end
            S_STOP: begin
                if (tick) begin
                    if (os_cnt_q == OS_LAST) begin
                        os_cnt_d  = '0;
                        state_d   = S_IDLE;
                        done_good = rx_s;
                        done_bad  = !rx_s;
                    end else begin
                        os_cnt_d = os_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // A completing good byte always wins over a same-cycle clear.
    always_comb begin
        data_d      = data_q;
        flag_d      = flag_q;
        overrun_d   = overrun_q;
        frame_err_d = frame_err_q;
        if (i_rx_clear) begin
            flag_d      = 1'b0;
            overrun_d   = 1'b0;
            frame_err_d = 1'b0;
        end
        if (done_good) begin
            flag_d = 1'b1;
            data_d = shreg_q;
            if (flag_q && !i_rx_clear) begin
                overrun_d = 1'b1;
            end
        end
        if (done_bad) begin
            frame_err_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            state_q     <= S_IDLE;
            os_cnt_q    <= '0;
            bit_idx_q   <= '0;
            shreg_q     <= '0;
            data_q      <= '0;
            flag_q      <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            state_q     <= state_d;
            os_cnt_q    <= os_cnt_d;
            bit_idx_q   <= bit_idx_d;
            shreg_q     <= shreg_d;
            data_q      <= data_d;
            flag_q      <= flag_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign o_rx_flag_ready = flag_q;
    assign o_rx_data       = data_q;
    assign o_rx_overrun    = overrun_q;
    assign o_frame_error   = frame_err_q;
    assign o_rx_busy       = (dbg_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_unit.sv
// Directed bench for uart_rx_unit: frames are driven bit by bit, expected bytes
// are queued at send time and a monitor pops them as the DUT presents bytes.
module tb_uart_rx_unit;

    localparam int BIT_CYC = 16;
    // 2 sync flops + 1 detect cycle + (9*16 + 8) ticks to the stop sample.
    localparam int LATENCY = 155;

    logic       clk;
    logic       i_reset;
    logic       i_rx;
    logic       i_rx_clear;
    logic       flag;
    logic [7:0] data;
    logic       overrun;
    logic       frame_err;
    logic       busy;

    logic [7:0] exp_q[$];
    int         checks;
    int         errors;
    int         cyc;
    int         t_start;

    uart_rx_unit #(
        .CLK_FREQ   (1_600_000),
        .BAUD_RATE  (100_000),
        .OVERSAMPLE (16),
        .SIZE_TRAMA (8)
    ) dut (
        .i_clk           (clk),
        .i_reset         (i_reset),
        .i_rx            (i_rx),
        .i_rx_clear      (i_rx_clear),
        .o_rx_flag_ready (flag),
        .o_rx_data       (data),
        .o_rx_overrun    (overrun),
        .o_frame_error   (frame_err),
        .o_rx_busy       (busy)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- checking helper ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- driver ----------------
    // Call at a falling clock edge; cut > 0 abandons the frame after that many cycles.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int cut);
        logic [9:0] bits;
        int n;
        bits = {stop_bit, b, 1'b0};
        n = 0;
        for (int i = 0; i < 10; i++) begin
            i_rx = bits[i];
            if (i == 0) t_start = cyc;
            for (int k = 0; k < BIT_CYC; k++) begin
                @(negedge clk);
                n++;
                if (cut > 0 && n >= cut) begin
                    i_rx = 1'b1;
                    return;
                end
            end
        end
        i_rx = 1'b1;
    endtask

    // ---------------- scoreboard monitor ----------------
    logic       flag_prev;
    logic [7:0] data_prev;

    initial begin
        flag_prev = 1'b0;
        data_prev = 8'h00;
        forever begin
            @(negedge clk);
            if (i_reset && flag && (!flag_prev || data != data_prev)) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_byte", {24'h0, data}, 32'hFFFF_FFFF);
                end else begin
                    check("rx_byte", {24'h0, data}, {24'h0, exp_q.pop_front()});
                    check("rx_latency", cyc - t_start, LATENCY);
                end
            end
            flag_prev = flag;
            data_prev = data;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        checks     = 0;
        errors     = 0;
        t_start    = 0;
        i_reset    = 1'b0;
        i_rx       = 1'b1;
        i_rx_clear = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_flag", flag, 0);
        check("reset_data", data, 0);
        check("reset_overrun", overrun, 0);
        check("reset_frame_err", frame_err, 0);
        check("reset_busy", busy, 0);
        i_reset = 1'b1;
        repeat (4) @(negedge clk);

        // False start: 5-cycle glitch.
        i_rx = 1'b0;
        repeat (4) @(negedge clk);
        check("glitch_busy_high", busy, 1);
        @(negedge clk);
        i_rx = 1'b1;
        repeat (15) @(negedge clk);
        check("glitch_busy_low", busy, 0);
        check("glitch_flag", flag, 0);
        check("glitch_data", data, 0);

        // Single byte, held until cleared.
        exp_q.push_back(8'h63);
        send_frame(8'h63, 1'b1, 0);
        repeat (20) @(negedge clk);
        check("single_flag_held", flag, 1);
        i_rx_clear = 1'b1;
        @(negedge clk);
        i_rx_clear = 1'b0;
        check("single_flag_cleared", flag, 0);
        check("single_data_kept", data, 8'h63);

        // Framing error: stop bit low.
        send_frame(8'h55, 1'b0, 0);
        repeat (40) @(negedge clk);
        check("ferr_set", frame_err, 1);
        check("ferr_flag", flag, 0);
        check("ferr_data_kept", data, 8'h63);
        i_rx_clear = 1'b1;
        @(negedge clk);
        i_rx_clear = 1'b0;
        check("ferr_cleared", frame_err, 0);

        // Overrun: two bytes without clearing.
        exp_q.push_back(8'h73);
        send_frame(8'h73, 1'b1, 0);
        exp_q.push_back(8'h6E);
        send_frame(8'h6E, 1'b1, 0);
        repeat (10) @(negedge clk);
        check("ovr_data", data, 8'h6E);
        check("ovr_flag", flag, 1);
        check("ovr_set", overrun, 1);
        i_rx_clear = 1'b1;
        @(negedge clk);
        i_rx_clear = 1'b0;
        check("ovr_cleared", overrun, 0);
        check("ovr_flag_cleared", flag, 0);

        // Completion while clear is held high.
        i_rx_clear = 1'b1;
        exp_q.push_back(8'hFF);
        fork
            send_frame(8'hFF, 1'b1, 0);
            begin
                repeat (LATENCY) @(negedge clk);
                check("simul_flag_set", flag, 1);
                check("simul_data", data, 8'hFF);
                check("simul_no_overrun", overrun, 0);
                @(negedge clk);
                check("simul_flag_cleared", flag, 0);
            end
        join
        i_rx_clear = 1'b0;
        repeat (5) @(negedge clk);

        // Asynchronous reset during bit 3 of 0xA5.
        send_frame(8'hA5, 1'b1, 4 * BIT_CYC + 8);
        check("midframe_busy", busy, 1);
        #2 i_reset = 1'b0;
        #1;
        check("areset_flag", flag, 0);
        check("areset_data", data, 0);
        check("areset_overrun", overrun, 0);
        check("areset_frame_err", frame_err, 0);
        check("areset_busy", busy, 0);
        repeat (3) @(negedge clk);
        i_reset = 1'b1;
        repeat (5) @(negedge clk);
        exp_q.push_back(8'h64);
        send_frame(8'h64, 1'b1, 0);
        repeat (10) @(negedge clk);
        check("post_reset_flag", flag, 1);
        check("post_reset_data", data, 8'h64);
        check("post_reset_busy", busy, 0);

        check("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
